// File: rtl/sha256_pkg.sv
// Shared SHA-256 constants, FSM state encoding and round/schedule helpers.
// Used by sha256_engine and sha256_wsched (optional SHA256_HASH_CHAIN_EN lives in the top).
package sha256_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READ    = 3'd1,
    ST_COMPUTE = 3'd2,
    ST_WRITE   = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  // Index 0 is word a / H0, index 7 is word h / H7.
  typedef logic [0:7][31:0] sha_state_t;

  localparam sha_state_t IV = {
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  function automatic logic [31:0] ror(input logic [31:0] x, input int unsigned n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] bsig0(input logic [31:0] x);
    return ror(x, 2) ^ ror(x, 13) ^ ror(x, 22);
  endfunction

  function automatic logic [31:0] bsig1(input logic [31:0] x);
    return ror(x, 6) ^ ror(x, 11) ^ ror(x, 25);
  endfunction

  function automatic logic [31:0] ssig0(input logic [31:0] x);
    return ror(x, 7) ^ ror(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] ssig1(input logic [31:0] x);
    return ror(x, 17) ^ ror(x, 19) ^ (x >> 10);
  endfunction

  function automatic sha_state_t sha_round(input sha_state_t s, input logic [31:0] k,
                                           input logic [31:0] w);
    logic [31:0] t1;
    logic [31:0] t2;
    t1 = s[7] + bsig1(s[4]) + ((s[4] & s[5]) ^ (~s[4] & s[6])) + k + w;
    t2 = bsig0(s[0]) + ((s[0] & s[1]) ^ (s[0] & s[2]) ^ (s[1] & s[2]));
    return {t1 + t2, s[0], s[1], s[2], s[3] + t1, s[4], s[5], s[6]};
  endfunction

endpackage

// File: rtl/sha256_wsched.sv
// Message schedule step: from a 16-word window W[t..t+15] produce W[t] and W[t+16].
// Word k of the window sits at bits [511-32k -: 32].
module sha256_wsched
  import sha256_pkg::*;
(
  input  logic [511:0] win_i,
  output logic [31:0]  w_t_o,
  output logic [31:0]  w_next_o
);

  logic [31:0] w0, w1, w9, w14;

  assign w0  = win_i[511 -: 32];
  assign w1  = win_i[479 -: 32];
  assign w9  = win_i[223 -: 32];
  assign w14 = win_i[63 -: 32];

  assign w_t_o    = w0;
  assign w_next_o = ssig1(w14) + w9 + ssig0(w1) + w0;

endmodule

// File: rtl/sha256_engine.sv
// Memory-mapped SHA-256 engine: reads a word message, pads in hardware, writes the digest.
// Define SHA256_HASH_CHAIN_EN to add the chain input (continue from the previous digest).
module sha256_engine
  import sha256_pkg::*;
#(
  parameter int ADDR_W       = 16,
  parameter int READ_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
`ifdef SHA256_HASH_CHAIN_EN
  input  logic              chain,
`endif
  input  logic [15:0]       msg_len_words,
  input  logic [ADDR_W-1:0] input_addr,
  input  logic [ADDR_W-1:0] hash_addr,
  output logic              busy,
  output logic              done,
  output logic              memory_clk,
  output logic              enable_write,
  output logic [ADDR_W-1:0] memory_addr,
  output logic [31:0]       memory_write_data,
  input  logic [31:0]       memory_read_data,
  output logic [2:0]        dbg_state
);

  localparam logic [6:0] RD_LAST = 7'(15 + READ_LATENCY);

  state_t                          state_q, state_d;
  logic [6:0]                      cnt_q, cnt_d;
  logic [12:0]                     blk_q, blk_d, nblk_q, nblk_d;
  logic [15:0]                     len_q, len_d;
  logic [ADDR_W-1:0]               in_addr_q, in_addr_d, hash_addr_q, hash_addr_d;
  logic [63:0]                     bits_q, bits_d;
  sha_state_t                      h_q, h_d, s_q, s_d;
  logic [0:15][31:0]               win_q, win_d;
  logic [READ_LATENCY-1:0]         pv_q, pv_d;
  logic [READ_LATENCY-1:0][3:0]    ps_q, ps_d;

  logic        use_chain;
  logic [16:0] gidx;
  logic [3:0]  slot;
  logic        rd_slot, rd_mem, last_blk;
  logic [31:0] pad_word, w_t, w_next;

`ifdef SHA256_HASH_CHAIN_EN
  assign use_chain = chain;
`else
  assign use_chain = 1'b0;
`endif

  sha256_wsched u_wsched (
    .win_i    (win_q),
    .w_t_o    (w_t),
    .w_next_o (w_next)
  );

  assign slot     = cnt_q[3:0];
  assign gidx     = {blk_q, slot};
  assign rd_slot  = (state_q == ST_READ) && (cnt_q < 7'd16);
  assign rd_mem   = rd_slot && (gidx < {1'b0, len_q});
  assign last_blk = (blk_q == nblk_q - 13'd1);

  always_comb begin
    pad_word = 32'd0;
    if (gidx == {1'b0, len_q})          pad_word = 32'h8000_0000;
    else if (last_blk && slot == 4'd14) pad_word = bits_q[63:32];
    else if (last_blk && slot == 4'd15) pad_word = bits_q[31:0];
  end

  assign memory_clk        = clk;
  assign busy              = (state_q == ST_READ) || (state_q == ST_COMPUTE) || (state_q == ST_WRITE);
  assign done              = (state_q == ST_DONE);
  assign enable_write      = (state_q == ST_WRITE);
  assign memory_write_data = (state_q == ST_WRITE) ? h_q[cnt_q[2:0]] : 32'd0;
  assign dbg_state         = state_q;

  always_comb begin
    memory_addr = '0;
    if (rd_mem)                   memory_addr = in_addr_q + ADDR_W'(gidx);
    else if (state_q == ST_WRITE) memory_addr = hash_addr_q + ADDR_W'(cnt_q[2:0]);
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    blk_d       = blk_q;
    nblk_d      = nblk_q;
    len_d       = len_q;
    in_addr_d   = in_addr_q;
    hash_addr_d = hash_addr_q;
    bits_d      = bits_q;
    h_d         = h_q;
    s_d         = s_q;
    win_d       = win_q;

    // Tag pipeline follows each issued read so the word lands in its slot READ_LATENCY later.
    pv_d    = '0;
    ps_d    = '0;
    pv_d[0] = rd_mem;
    ps_d[0] = slot;
    for (int i = 1; i < READ_LATENCY; i++) begin
      pv_d[i] = pv_q[i-1];
      ps_d[i] = ps_q[i-1];
    end
    if (pv_q[READ_LATENCY-1]) win_d[ps_q[READ_LATENCY-1]] = memory_read_data;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          len_d       = msg_len_words;
          in_addr_d   = input_addr;
          hash_addr_d = hash_addr;
          nblk_d      = 13'((17'(msg_len_words) + 17'd2) >> 4) + 13'd1;
          bits_d      = (use_chain ? bits_q : 64'd0) + {43'd0, msg_len_words, 5'd0};
          h_d         = use_chain ? h_q : IV;
          blk_d       = 13'd0;
          cnt_d       = 7'd0;
          state_d     = ST_READ;
        end
      end
      ST_READ: begin
        if (rd_slot && !rd_mem) win_d[slot] = pad_word;
        if (cnt_q == RD_LAST) begin
          s_d     = h_q;
          cnt_d   = 7'd0;
          state_d = ST_COMPUTE;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      ST_COMPUTE: begin
        if (cnt_q < 7'd64) begin
          s_d   = sha_round(s_q, K[cnt_q[5:0]], w_t);
          win_d = {win_q[1:15], w_next};
          cnt_d = cnt_q + 7'd1;
        end else begin
          for (int i = 0; i < 8; i++) h_d[i] = h_q[i] + s_q[i];
          cnt_d = 7'd0;
          if (last_blk) begin
            state_d = ST_WRITE;
          end else begin
            blk_d   = blk_q + 13'd1;
            state_d = ST_READ;
          end
        end
      end
      ST_WRITE: begin
        if (cnt_q == 7'd7) begin
          cnt_d   = 7'd0;
          state_d = ST_DONE;
        end else begin
          cnt_d = cnt_q + 7'd1;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      blk_q       <= '0;
      nblk_q      <= '0;
      len_q       <= '0;
      in_addr_q   <= '0;
      hash_addr_q <= '0;
      bits_q      <= '0;
      h_q         <= '0;
      s_q         <= '0;
      win_q       <= '0;
      pv_q        <= '0;
      ps_q        <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      blk_q       <= blk_d;
      nblk_q      <= nblk_d;
      len_q       <= len_d;
      in_addr_q   <= in_addr_d;
      hash_addr_q <= hash_addr_d;
      bits_q      <= bits_d;
      h_q         <= h_d;
      s_q         <= s_d;
      win_q       <= win_d;
      pv_q        <= pv_d;
      ps_q        <= ps_d;
    end
  end

endmodule
